// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the multi-cycle MIPS datapath: default register-file
// geometry, architectural register numbers and the RegDst mux encodings used
// upstream to pick the write-back destination.
// No ports (package).
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    // Write-destination select driven by the control FSM.
    typedef enum logic [1:0] {
        REGDST_RA = 2'b00,
        REGDST_RT = 2'b01,
        REGDST_RD = 2'b10
    } reg_dst_e;

endpackage

// File: rtl/register_file_if.sv
// -----------------------------------------------------------------------------
// register_file_if
// Bundles the write port, the two read addresses and all read results of the
// register file.
//   master : datapath/control side (drives RegWre, WriteReg, WriteData, rs, rt;
//            receives ReadData1, ReadData2, ADR, BDR)
//   slave  : register file side
// -----------------------------------------------------------------------------
interface register_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);

    logic              RegWre;
    logic [ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic [DATA_W-1:0] ADR;
    logic [DATA_W-1:0] BDR;

    modport master (
        output RegWre, WriteReg, WriteData, rs, rt,
        input  ReadData1, ReadData2, ADR, BDR
    );

    modport slave (
        input  RegWre, WriteReg, WriteData, rs, rt,
        output ReadData1, ReadData2, ADR, BDR
    );

endinterface

// File: rtl/reg_bypass.sv
// -----------------------------------------------------------------------------
// reg_bypass
// Write-first operand selection for one operand latch.
//   addr        in  : register being read
//   reg_wre     in  : write enable of the current cycle
//   write_reg   in  : register being written this cycle
//   write_data  in  : value being written this cycle
//   stored_data in  : current array contents at addr
//   data        out : $0 -> 0, same-cycle write -> write_data, else stored_data
// -----------------------------------------------------------------------------
module reg_bypass #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              reg_wre,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] stored_data,
    output logic [DATA_W-1:0] data
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

    // Priority select: $0 wins over a (dropped) write to $0, then write-first.
    always_comb begin
        data = {DATA_W{1'b0}};
        if (addr == ZERO_ADDR) begin
            data = {DATA_W{1'b0}};
        end else if (reg_wre == 1'b1 && write_reg == addr) begin
            data = write_data;
        end else begin
            data = stored_data;
        end
    end

endmodule

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
// Two-read, one-write register file for the multi-cycle MIPS datapath with
// $0 hard-wired to zero, combinational read ports and the A/B operand latches
// that capture every clock with write-first bypass.
//   CLK   in : rising-edge clock
//   Reset in : asynchronous active-high reset (clears array and latches)
//   bus      : register_file_if.slave (write port, rs/rt, ReadData1/2, ADR/BDR)
// The interface instance must use the same DATA_W/ADDR_W as this module.
// -----------------------------------------------------------------------------
module register_file
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input logic           CLK,
    input logic           Reset,
    register_file_if.slave bus
);

    localparam int                NUM_REGS  = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

    logic [DATA_W-1:0] regs_r [NUM_REGS];
    logic [DATA_W-1:0] adr_r;
    logic [DATA_W-1:0] bdr_r;
    logic [DATA_W-1:0] rd1_s;
    logic [DATA_W-1:0] rd2_s;
    logic [DATA_W-1:0] byp_a_s;
    logic [DATA_W-1:0] byp_b_s;
    logic              wr_en_s;

    // Write qualifier; an unknown WriteReg is harmless because RegWre=0 masks it.
    always_comb begin
        wr_en_s = 1'b0;
        if (bus.RegWre == 1'b1 && bus.WriteReg != ZERO_ADDR) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Register array; Reset has priority so a coincident write is lost.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_en_s) begin
            regs_r[bus.WriteReg] <= bus.WriteData;
        end
    end

    // Combinational read port 1 (no bypass: same-cycle writes show after the edge).
    always_comb begin
        rd1_s = {DATA_W{1'b0}};
        if (bus.rs == ZERO_ADDR) begin
            rd1_s = {DATA_W{1'b0}};
        end else begin
            rd1_s = regs_r[bus.rs];
        end
    end

    // Combinational read port 2.
    always_comb begin
        rd2_s = {DATA_W{1'b0}};
        if (bus.rt == ZERO_ADDR) begin
            rd2_s = {DATA_W{1'b0}};
        end else begin
            rd2_s = regs_r[bus.rt];
        end
    end

    reg_bypass #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_bypass_a (
        .addr        (bus.rs),
        .reg_wre     (bus.RegWre),
        .write_reg   (bus.WriteReg),
        .write_data  (bus.WriteData),
        .stored_data (rd1_s),
        .data        (byp_a_s)
    );

    reg_bypass #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_bypass_b (
        .addr        (bus.rt),
        .reg_wre     (bus.RegWre),
        .write_reg   (bus.WriteReg),
        .write_data  (bus.WriteData),
        .stored_data (rd2_s),
        .data        (byp_b_s)
    );

    // Operand latches A/B capture the bypassed operands every edge.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            adr_r <= {DATA_W{1'b0}};
            bdr_r <= {DATA_W{1'b0}};
        end else begin
            adr_r <= byp_a_s;
            bdr_r <= byp_b_s;
        end
    end

    assign bus.ReadData1 = rd1_s;
    assign bus.ReadData2 = rd2_s;
    assign bus.ADR       = adr_r;
    assign bus.BDR       = bdr_r;

endmodule

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
// Self-checking bench for register_file: a reference array tracks the
// architectural state, expected latch values are queued when each edge's
// stimulus is applied and popped/compared after the edge.
// -----------------------------------------------------------------------------
module tb_register_file;
    import mips_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    register_file_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    register_file #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .CLK   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mdl [32];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;

    task automatic drive(input logic we, input logic [AW-1:0] wr, input logic [DW-1:0] wd,
                         input logic [AW-1:0] a, input logic [AW-1:0] b);
        bus.RegWre    = we;
        bus.WriteReg  = wr;
        bus.WriteData = wd;
        bus.rs        = a;
        bus.rt        = b;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    endtask

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
        if (rst || a == 5'd0) return 32'h0;
        return mdl[a];
    endfunction

    function automatic logic [DW-1:0] model_byp(input logic [AW-1:0] a);
        if (rst || a == 5'd0) return 32'h0;
        if (bus.RegWre === 1'b1 && bus.WriteReg === a) return bus.WriteData;
        return mdl[a];
    endfunction

    // Queue the latch expectations for the coming edge, update the model, take the edge.
    task automatic tick();
        exp_q.push_back(model_byp(bus.rs));
        exp_q.push_back(model_byp(bus.rt));
        if (!rst && bus.RegWre === 1'b1 && bus.WriteReg != 5'd0) mdl[bus.WriteReg] = bus.WriteData;
        @(posedge clk);
        #1;
    endtask

    task automatic pop_pair();
        if (exp_q.size() < 2) begin
            failures++;
            checks++;
            $display("FAIL scoreboard_underflow size=%0d required>=2", exp_q.size());
            ea = 32'h0;
            eb = 32'h0;
        end else begin
            ea = exp_q.pop_front();
            eb = exp_q.pop_front();
        end
    endtask

    task automatic test_reset();
        clear_model();
        drive(1'b1, 5'd5, 32'h0000CAFE, 5'd5, 5'd31);
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.ReadData1 !== 32'h0) begin failures++; $display("FAIL reset_rd1 got=%h exp=%h", bus.ReadData1, 32'h0); end
        checks++; if (bus.ReadData2 !== 32'h0) begin failures++; $display("FAIL reset_rd2 got=%h exp=%h", bus.ReadData2, 32'h0); end
        checks++; if (bus.ADR !== 32'h0) begin failures++; $display("FAIL reset_adr got=%h exp=%h", bus.ADR, 32'h0); end
        checks++; if (bus.BDR !== 32'h0) begin failures++; $display("FAIL reset_bdr got=%h exp=%h", bus.BDR, 32'h0); end
        tick();
        pop_pair();
        checks++; if (bus.ADR !== ea) begin failures++; $display("FAIL reset_edge_adr got=%h exp=%h", bus.ADR, ea); end
        checks++; if (bus.BDR !== eb) begin failures++; $display("FAIL reset_edge_bdr got=%h exp=%h", bus.BDR, eb); end
        #2 rst = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
        #1;
        checks++; if (bus.ReadData1 !== model_rd(5'd5)) begin failures++; $display("FAIL reset_blocks_write got=%h exp=%h", bus.ReadData1, model_rd(5'd5)); end
    endtask

    task automatic test_write_read();
        drive(1'b1, 5'd8, 32'hDEADBEEF, 5'd8, 5'd0);
        #1;
        checks++; if (bus.ReadData1 !== model_rd(5'd8)) begin failures++; $display("FAIL wr_no_comb_bypass got=%h exp=%h", bus.ReadData1, model_rd(5'd8)); end
        tick();
        pop_pair();
        checks++; if (bus.ADR !== ea) begin failures++; $display("FAIL wr_adr_bypass got=%h exp=%h", bus.ADR, ea); end
        drive(1'b0, 5'd0, 32'h0, 5'd8, 5'd8);
        #1;
        checks++; if (bus.ReadData1 !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_rd1 got=%h exp=%h", bus.ReadData1, 32'hDEADBEEF); end
        tick();
        pop_pair();
        checks++; if (bus.ADR !== ea) begin failures++; $display("FAIL wr_adr got=%h exp=%h", bus.ADR, ea); end
        checks++; if (bus.BDR !== eb) begin failures++; $display("FAIL wr_bdr got=%h exp=%h", bus.BDR, eb); end
    endtask

    task automatic test_zero();
        drive(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0);
        tick();
        pop_pair();
        checks++; if (bus.ADR !== ea) begin failures++; $display("FAIL zero_adr got=%h exp=%h", bus.ADR, ea); end
        checks++; if (bus.BDR !== eb) begin failures++; $display("FAIL zero_bdr got=%h exp=%h", bus.BDR, eb); end
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd8);
        #1;
        checks++; if (bus.ReadData1 !== 32'h0) begin failures++; $display("FAIL zero_rd1 got=%h exp=%h", bus.ReadData1, 32'h0); end
        checks++; if (bus.ReadData2 !== model_rd(5'd8)) begin failures++; $display("FAIL zero_other_reg got=%h exp=%h", bus.ReadData2, model_rd(5'd8)); end
    endtask

    task automatic test_bypass();
        drive(1'b1, 5'd9, 32'h1, 5'd0, 5'd0);
        tick();
        exp_q.delete();
        drive(1'b1, 5'd9, 32'h2, 5'd9, 5'd9);
        #1;
        checks++; if (bus.ReadData1 !== model_rd(5'd9)) begin failures++; $display("FAIL byp_pre_edge_rd1 got=%h exp=%h", bus.ReadData1, model_rd(5'd9)); end
        tick();
        pop_pair();
        checks++; if (bus.ADR !== ea) begin failures++; $display("FAIL byp_adr got=%h exp=%h", bus.ADR, ea); end
        checks++; if (bus.BDR !== eb) begin failures++; $display("FAIL byp_bdr got=%h exp=%h", bus.BDR, eb); end
        checks++; if (bus.ReadData1 !== 32'h2) begin failures++; $display("FAIL byp_rd1 got=%h exp=%h", bus.ReadData1, 32'h2); end
    endtask

    task automatic test_no_enable();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 5'd9, 32'h0000FFFF, 5'd9, 5'd8);
            tick();
            pop_pair();
            checks++; if (bus.ADR !== ea) begin failures++; $display("FAIL noen_adr[%0d] got=%h exp=%h", i, bus.ADR, ea); end
            checks++; if (bus.ReadData1 !== 32'h2) begin failures++; $display("FAIL noen_rd1[%0d] got=%h exp=%h", i, bus.ReadData1, 32'h2); end
        end
        bus.WriteReg = 5'bxxxxx;
        bus.RegWre   = 1'b0;
        tick();
        exp_q.delete();
        checks++; if (bus.ReadData1 !== model_rd(5'd9)) begin failures++; $display("FAIL xaddr_r9 got=%h exp=%h", bus.ReadData1, model_rd(5'd9)); end
        checks++; if (bus.ReadData2 !== model_rd(5'd8)) begin failures++; $display("FAIL xaddr_r8 got=%h exp=%h", bus.ReadData2, model_rd(5'd8)); end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 5'd31, 32'hA5A5A5A5, 5'd0, 5'd31);
        tick();
        exp_q.delete();
        checks++; if (bus.ReadData2 !== model_rd(REG_RA)) begin failures++; $display("FAIL ar_pre got=%h exp=%h", bus.ReadData2, model_rd(REG_RA)); end
        drive(1'b1, 5'd31, 32'h12345678, 5'd0, 5'd31);
        #2 rst = 1'b1;
        clear_model();
        #1;
        checks++; if (bus.ReadData2 !== 32'h0) begin failures++; $display("FAIL ar_async_rd2 got=%h exp=%h", bus.ReadData2, 32'h0); end
        checks++; if (bus.BDR !== 32'h0) begin failures++; $display("FAIL ar_async_bdr got=%h exp=%h", bus.BDR, 32'h0); end
        tick();
        pop_pair();
        checks++; if (bus.BDR !== eb) begin failures++; $display("FAIL ar_edge_bdr got=%h exp=%h", bus.BDR, eb); end
        #2 rst = 1'b0;
        drive(1'b0, 5'd31, 32'h0, 5'd0, 5'd31);
        #1;
        checks++; if (bus.ReadData2 !== 32'h0) begin failures++; $display("FAIL ar_write_lost got=%h exp=%h", bus.ReadData2, 32'h0); end
        drive(1'b1, 5'd31, 32'h00000077, 5'd31, 5'd31);
        tick();
        pop_pair();
        checks++; if (bus.BDR !== eb) begin failures++; $display("FAIL ar_resume_bdr got=%h exp=%h", bus.BDR, eb); end
        checks++; if (bus.ReadData2 !== 32'h00000077) begin failures++; $display("FAIL ar_resume_rd2 got=%h exp=%h", bus.ReadData2, 32'h00000077); end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        for (int i = 0; i < 60; i++) begin
            a = 5'($urandom_range(0, 7));
            b = (($urandom % 4) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            drive(1'($urandom % 2), 5'($urandom_range(0, 7)), 32'($urandom), a, b);
            #1;
            checks++; if (bus.ReadData1 !== model_rd(a)) begin failures++; $display("FAIL b2b_rd1[%0d] got=%h exp=%h", i, bus.ReadData1, model_rd(a)); end
            checks++; if (bus.ReadData2 !== model_rd(b)) begin failures++; $display("FAIL b2b_rd2[%0d] got=%h exp=%h", i, bus.ReadData2, model_rd(b)); end
            tick();
            pop_pair();
            checks++; if (bus.ADR !== ea) begin failures++; $display("FAIL b2b_adr[%0d] got=%h exp=%h", i, bus.ADR, ea); end
            checks++; if (bus.BDR !== eb) begin failures++; $display("FAIL b2b_bdr[%0d] got=%h exp=%h", i, bus.BDR, eb); end
        end
    endtask

    initial begin
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        test_reset();
        test_write_read();
        test_zero();
        test_bypass();
        test_no_enable();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/register_file.md
# register_file

Two-read, one-write general-purpose register file for the multi-cycle MIPS datapath. It is the consumer of the selected write-register address (`$31`, `rt` or `rd`) and the source of operands for the ALU. It holds 32 architectural registers with `$0` hard-wired to zero. It provides combinational read data plus the multi-cycle A/B operand latches, which capture every clock with write-first bypass.

## Interface
Parameters:
- `DATA_W`, default 32: register width.
- `ADDR_W`, default 5: register address width; register count is 2**ADDR_W.

Ports:
- `CLK`, in, 1: single clock; all state updates on rising edge.
- `Reset`, in, 1: asynchronous, active-high reset.
- `RegWre`, in, 1: write enable for the current cycle.
- `WriteReg`, in, ADDR_W: destination register, already selected upstream (`$31`, `rt` or `rd`).
- `WriteData`, in, DATA_W: write-back value.
- `rs`, in, ADDR_W: read address, port 1.
- `rt`, in, ADDR_W: read address, port 2.
- `ReadData1`, out, DATA_W: combinational contents of `rs`.
- `ReadData2`, out, DATA_W: combinational contents of `rt`.
- `ADR`, out, DATA_W: operand latch A, registered.
- `BDR`, out, DATA_W: operand latch B, registered.

## Operation
- **Storage:** array `regs[0..2**ADDR_W-1]`.
- **Write:**
  - On a rising `CLK` with `RegWre=1` and `WriteReg!=0`, `regs[WriteReg] <= WriteData`.
  - Writes to `$0` are silently dropped.
  - With `RegWre=0`, the array is unchanged.
- **Combinational read:**
  - `ReadData1 = (rs==0) ? 0 : regs[rs]`; `ReadData2` is the same using `rt`.
  - No bypass. A same-cycle write shows on `ReadData*` only after the edge.
- **Latches:**
  - Every rising edge, `ADR <= bypass(rs)` and `BDR <= bypass(rt)`.
  - `bypass(a) = 0` if `a==0`.
  - Otherwise `bypass(a) = WriteData` if `RegWre && WriteReg==a`.
  - Otherwise `bypass(a) = regs[a]` (write-first).
- **Reset:**
  - While `Reset=1`, immediately and independently of `CLK`: all `regs` = 0, `ADR` = 0, `BDR` = 0.
  - Consequently `ReadData1` and `ReadData2` read 0.
  - Writes are blocked while `Reset` is high.
- **Reset mid-operation:** a write coincident with `Reset` assertion is lost. After deassertion, the first rising edge behaves normally.
- **Unknown inputs:** X on `WriteReg` while `RegWre=0` must not corrupt any register.

## Timing
- **Read latency:** `ReadData1`/`ReadData2` 0 cycles (combinational); `ADR`/`BDR` 1 cycle.
- **Write latency:** a write at edge N is visible on `ReadData*` after edge N and in the latches at edge N+1. Via bypass, the latches also see it at edge N.
- **Simultaneous events:**
  - `rs==rt==WriteReg!=0` with `RegWre=1`: both latches get `WriteData`.
  - `WriteReg==0` with `RegWre=1`: no bypass, and latches reading `$0` get 0.
- **Reset values:** every output is 0.
- **Handshake:** none. `RegWre` is a one-cycle qualifier driven by the control FSM in its write-back states.

## Structure
- **Shared package `mips_pkg`:**
  - `REG_ZERO = 5'd0`, `REG_RA = 5'd31`.
  - `DATA_W`, `ADDR_W` defaults.
  - `RegDst` encodings: `00`=`$31`, `01`=`rt`, `10`=`rd`.
- **Sub-module `reg_bypass`:** a small combinational sub-module implementing `bypass(a)`, instantiated twice (A and B). Everything else is in the top module.

## Test plan
1. Reset, then read: assert `Reset`, then set `rs=5`, `rt=31`. Required: `ReadData1=ReadData2=ADR=BDR=0`.
2. Write then read: `RegWre=1`, `WriteReg=8`, `WriteData=0xDEADBEEF` for one edge, then `rs=8`. Required: `ReadData1=0xDEADBEEF` immediately, and `ADR=0xDEADBEEF` after the next edge.
3. `$0` protection: write `0x12345678` to `WriteReg=0`, then `rs=0`. Required: `ReadData1=0` and `ADR=0`.
4. Bypass: `regs[9]=1`; at one edge drive `RegWre=1`, `WriteReg=9`, `WriteData=2`, `rs=rt=9`. Required: after that edge `ADR=BDR=2` and `ReadData1=2`.
5. No-enable: `RegWre=0`, `WriteReg=9`, `WriteData=0xFFFF` for 3 edges. Required: `regs[9]` unchanged at 2.
6. Async reset mid-write: `regs[31]=0xA5A5A5A5`; assert `Reset` between edges while `RegWre=1` targets `$31`. Required: `ReadData2` (`rt=31`) goes to 0 before the next edge and stays 0 through deassertion.
